divider_32b: RTL and testbench

- Iterative restoring divider: one quotient bit per clock using a WIDTH+1-bit subtract and compare.
- Arithmetic inverse companion to the team's combinational ripple adder.
- Serves the ALU's DIV/DIVU/REM/REMU path.
- Valid/ready on the operand side and the result side; one operation in flight.

---
 rtl/divider_32b_pkg.sv | 18 +
 rtl/divider_32b_sub_cmp_nb.sv | 20 ++
 rtl/divider_32b.sv | 144 ++++++++++++++
 tb/tb_divider_32b.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_32b_pkg.sv
// divider_pkg: shared FSM state type and sizing constants for the iterative divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Width of an iteration counter that must hold values up to w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/divider_32b_sub_cmp_nb.sv
// sub_cmp_nb: WIDTH+1-bit subtract-and-compare used by one restoring step.
// The difference is formed as a + ~b + 1; its top bit is the borrow flag.
// The top bit acts as a borrow because the partial remainder stays below
// twice the divisor.
module sub_cmp_nb #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH:0]   b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH:0] d;

    assign d        = a_i + ~b_i + {{WIDTH{1'b0}}, 1'b1};
    assign diff_o   = d[WIDTH-1:0];
    assign borrow_o = d[WIDTH];

endmodule

// File: rtl/divider_32b.sv
// divider_32b: iterative restoring divider, one quotient bit per clock.
// Valid/ready on operands and results; a single operation in flight.
// Optional signed support via macro DIVIDER_32B_SIGNED_EN (adds signed_op).
module divider_32b
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_32B_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             sop;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rprime;
    logic [WIDTH-1:0] diff;
    logic             borrow;

`ifdef DIVIDER_32B_SIGNED_EN
    assign sop = signed_op;
`else
    assign sop = 1'b0;
`endif

    // Signed operations divide magnitudes; signs are restored at the output.
    assign mag_a = (sop && dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_b = (sop && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign rprime = {rem_q, quo_q[WIDTH-1]};

    sub_cmp_nb #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i      (rprime),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // Next-state: operand capture, one restoring step per RUN cycle, result hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (divisor == '0) begin
                        // Divide by zero skips iteration; raw dividend is reported.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        quo_d   = mag_a;
                        dvs_d   = mag_b;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        qneg_d  = sop && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d  = sop && dividend[WIDTH-1];
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = borrow ? rprime[WIDTH-1:0] : diff;
                quo_d = {quo_q[WIDTH-2:0], ~borrow};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign div_by_zero  = dbz_q;
    // Sign fixup is combinational; with unsigned operation the flags stay clear.
    assign quotient     = qneg_q ? -quo_q : quo_q;
    assign remainder    = rneg_q ? -rem_q : rem_q;

endmodule

// File: tb/tb_divider_32b.sv
// tb_divider_32b: directed, scoreboard-checked bench for divider_32b.
// Signed cases are included when DIVIDER_32B_SIGNED_EN is defined.
module tb_divider_32b;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIVIDER_32B_SIGNED_EN
    logic         sop;
`endif

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    divider_32b #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .dividend     (dividend),
        .divisor      (divisor),
`ifdef DIVIDER_32B_SIGNED_EN
        .signed_op    (sop),
`endif
        .result_valid (result_valid),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model built from the language's own division operators.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = W'($signed(a) / $signed(b));
                e.r = W'($signed(a) % $signed(b));
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, result_valid, 1);
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    task automatic release_result(input string tag);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk({tag, "_rel_srdy"}, start_ready, 1);
        chk({tag, "_rel_valid"}, result_valid, 0);
    endtask

    // Called #1 after a rising edge with the divider idle.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        start_valid = 1'b1;
        dividend    = a;
        divisor     = b;
`ifdef DIVIDER_32B_SIGNED_EN
        sop         = s;
`endif
        chk({tag, "_srdy"}, start_ready, 1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        sb.push_back(model(a, b, s));
        wait_valid(n);
        chk({tag, "_lat"}, n, (b == '0) ? 0 : W);
        check_result(tag);
        release_result(tag);
    endtask

    initial begin
        int   n;
        logic seen;
        exp_t e;
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        dividend     = '0;
        divisor      = '0;
`ifdef DIVIDER_32B_SIGNED_EN
        sop          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_srdy", start_ready, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of an operation: no result may appear.
        start_valid = 1'b1;
        dividend    = 32'd100;
        divisor     = 32'd7;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("mid_run_srdy", start_ready, 0);
        rst = 1'b1;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        chk("abort_srdy", start_ready, 1);
        chk("abort_valid", result_valid, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);
        do_op("post_rst", 32'd100, 32'd7, 1'b0);

        // Basic unsigned and boundary operands.
        do_op("ffff_div_16", 32'hFFFF_FFFF, 32'h10, 1'b0);
        do_op("small_div", 32'd5, 32'd9, 1'b0);
        do_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0);
        do_op("div_one", 32'hDEAD_BEEF, 32'd1, 1'b0);
        do_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("msb_set", 32'hC000_0001, 32'h8000_0000, 1'b0);
        do_op("div_zero", 32'd1234, 32'd0, 1'b0);

        // Backpressure: result held, start pulses ignored.
        start_valid = 1'b1;
        dividend    = 32'hFFFF_FFFF;
        divisor     = 32'h10;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        sb.push_back(model(32'hFFFF_FFFF, 32'h10, 1'b0));
        e = sb[0];
        wait_valid(n);
        chk("bp_lat", n, W);
        for (int i = 0; i < 20; i++) begin
            start_valid = (i % 4 == 1);
            dividend    = 32'(i);
            divisor     = 32'd3;
            @(posedge clk);
            #1;
            chk("bp_valid", result_valid, 1);
            chk("bp_srdy", start_ready, 0);
            chk("bp_q", quotient, e.q);
            chk("bp_r", remainder, e.r);
        end
        start_valid = 1'b0;
        check_result("bp");
        release_result("bp");
        @(posedge clk);
        #1;
        chk("bp_no_late_start", start_ready, 1);

        // Back-to-back: start_valid held high across the result handshake.
        start_valid = 1'b1;
        dividend    = 32'h8000_0000;
        divisor     = 32'd2;
        @(posedge clk);
        #1;
        sb.push_back(model(32'h8000_0000, 32'd2, 1'b0));
        dividend = 32'd7;
        divisor  = 32'd7;
        wait_valid(n);
        chk("b2b_a_lat", n, W);
        check_result("b2b_a");
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("b2b_gap_srdy", start_ready, 1);
        @(posedge clk);
        #1;
        sb.push_back(model(32'd7, 32'd7, 1'b0));
        start_valid = 1'b0;
        chk("b2b_b_taken", start_ready, 0);
        wait_valid(n);
        chk("b2b_b_lat", n, W);
        check_result("b2b_b");
        release_result("b2b_b");

`ifdef DIVIDER_32B_SIGNED_EN
        do_op("s_neg7_2", -32'sd7, 32'd2, 1'b1);
        do_op("s_7_neg2", 32'd7, -32'sd2, 1'b1);
        do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op("s_dbz", -32'sd5, 32'd0, 1'b1);
        do_op("u_neg_bits", -32'sd7, 32'd2, 1'b0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
